// File: rtl/mod_counter_nb_if.sv
// Control/status bundle for mod_counter_nb: count controls in, count and flags out.
// The master drives controls and observes the count; the slave is the counter itself.
interface mod_counter_nb_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             oneshot;
   logic             load;
   logic [WIDTH-1:0] ld_val;
   logic [WIDTH-1:0] modulus;
   logic [WIDTH-1:0] out;
   logic             tc;
   logic             wrap;
   logic             done;

   modport master (
      output en, up, oneshot, load, ld_val, modulus,
      input  out, tc, wrap, done
   );

   modport slave (
      input  en, up, oneshot, load, ld_val, modulus,
      output out, tc, wrap, done
   );
endinterface

// File: rtl/mod_counter_nb.sv
// Single-clock up/down modulus counter with load, terminal count, wrap pulse and one-shot halt.
// Optional enable prescaler is built only when COUNTER_PRESCALE_EN is defined.
module mod_counter_nb #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               PRESCALE  = 1
) (
   input  logic          clk,
   input  logic          clr,
   mod_counter_nb_if.slave bus
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] count_q;
   logic             wrap_q;
   logic             tc;
   logic             tick;
   logic             step_en;

   if (WIDTH < 2 || PRESCALE < 1) begin : g_param_check
      $error("mod_counter_nb: WIDTH must be >= 2 and PRESCALE >= 1");
   end

   // Terminal value depends on the direction presented this cycle, so a
   // direction change at the limit is judged against the new direction.
   assign tc = bus.up ? (count_q >= bus.modulus) : (count_q == '0);

`ifdef COUNTER_PRESCALE_EN
   localparam int              PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

   logic [PSC_W-1:0] psc_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         psc_q <= '0;
      end else if (bus.load) begin
         psc_q <= '0;
      end else if (bus.en && (state_q == RUN)) begin
         psc_q <= (psc_q == PSC_LAST) ? '0 : psc_q + 1'b1;
      end
   end

   assign tick = bus.en && (psc_q == PSC_LAST);
`else
   assign tick = bus.en;
`endif

   assign step_en = tick && (state_q == RUN);

   // NOTE: every flop below uses non-blocking assignment so all registers
   // update from the same pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: next state defaults to the current state first, so no path
   // through this block leaves state_d unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (bus.load) begin
         state_d = RUN;
      end else if (step_en && tc && bus.oneshot) begin
         state_d = HALT;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         count_q <= RESET_VAL;
         wrap_q  <= 1'b0;
      end else if (bus.load) begin
         count_q <= bus.ld_val;
         wrap_q  <= 1'b0;
      end else if (step_en) begin
         if (!tc) begin
            count_q <= bus.up ? count_q + 1'b1 : count_q - 1'b1;
            wrap_q  <= 1'b0;
         end else begin
            // One-shot counts the terminal value itself and then freezes on it.
            wrap_q <= 1'b1;
            if (!bus.oneshot) begin
               count_q <= bus.up ? '0 : bus.modulus;
            end
         end
      end else begin
         wrap_q <= 1'b0;
      end
   end

   always_comb begin
      bus.out  = count_q;
      bus.tc   = tc;
      bus.wrap = wrap_q;
      bus.done = (state_q == HALT);
   end

endmodule

// File: tb/tb_mod_counter_nb.sv
// Directed bench for mod_counter_nb; a PRESCALE=3 instance is added when COUNTER_PRESCALE_EN is defined.
module tb_mod_counter_nb;

   logic clk;
   logic clr;
   int   total;
   int   bad;

   mod_counter_nb_if #(.WIDTH(4)) bus ();

   mod_counter_nb #(
      .WIDTH    (4),
      .RESET_VAL(4'd0),
      .PRESCALE (1)
   ) u_dut (
      .clk(clk),
      .clr(clr),
      .bus(bus)
   );

`ifdef COUNTER_PRESCALE_EN
   mod_counter_nb_if #(.WIDTH(4)) bus_p ();

   mod_counter_nb #(
      .WIDTH    (4),
      .RESET_VAL(4'd0),
      .PRESCALE (3)
   ) u_dut_p3 (
      .clk(clk),
      .clr(clr),
      .bus(bus_p)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 ns after the rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.load = 1'b1; bus.ld_val = 4'd7; bus.en = 1'b0;
      bus.up = 1'b1; bus.modulus = 4'd9; bus.oneshot = 1'b0;
      step();
      total++; if (bus.out !== 4'd7) begin bad++; $display("FAIL reset.preload out got %0d want 7", bus.out); end
      bus.load = 1'b0;
      #2 clr = 1'b1;
      #1;
      total++; if (bus.out !== 4'd0) begin bad++; $display("FAIL reset.out got %0d want 0", bus.out); end
      total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL reset.wrap got %b want 0", bus.wrap); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset.done got %b want 0", bus.done); end
      total++; if (bus.tc !== 1'b0) begin bad++; $display("FAIL reset.tc got %b want 0", bus.tc); end
      @(negedge clk) clr = 1'b0;
   endtask

   task automatic test_up_wrap();
      logic [3:0] exp_out;
      bus.load = 1'b1; bus.ld_val = 4'd0; bus.en = 1'b0;
      bus.up = 1'b1; bus.modulus = 4'd9; bus.oneshot = 1'b0;
      step();
      bus.load = 1'b0; bus.en = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         step();
         exp_out = 4'(i % 10);
         total++; if (bus.out !== exp_out) begin bad++; $display("FAIL up_wrap.out edge %0d got %0d want %0d", i, bus.out, exp_out); end
         total++; if (bus.tc !== (exp_out == 4'd9)) begin bad++; $display("FAIL up_wrap.tc edge %0d got %b want %b", i, bus.tc, exp_out == 4'd9); end
         total++; if (bus.wrap !== (i == 10)) begin bad++; $display("FAIL up_wrap.wrap edge %0d got %b want %b", i, bus.wrap, i == 10); end
      end
   endtask

   task automatic test_down_load();
      logic [3:0] exp_o [5];
      logic       exp_w [5];
      exp_o = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
      exp_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      bus.load = 1'b1; bus.ld_val = 4'd3; bus.en = 1'b1; bus.up = 1'b0;
      step();
      total++; if (bus.out !== 4'd3) begin bad++; $display("FAIL down.load_wins out got %0d want 3", bus.out); end
      total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL down.load_wrap got %b want 0", bus.wrap); end
      bus.load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         total++; if (bus.out !== exp_o[i]) begin bad++; $display("FAIL down.out step %0d got %0d want %0d", i, bus.out, exp_o[i]); end
         total++; if (bus.wrap !== exp_w[i]) begin bad++; $display("FAIL down.wrap step %0d got %b want %b", i, bus.wrap, exp_w[i]); end
         total++; if (bus.tc !== (exp_o[i] == 4'd0)) begin bad++; $display("FAIL down.tc step %0d got %b want %b", i, bus.tc, exp_o[i] == 4'd0); end
      end
   endtask

   task automatic test_oneshot();
      bus.load = 1'b1; bus.ld_val = 4'd0; bus.en = 1'b0;
      bus.up = 1'b1; bus.modulus = 4'd5; bus.oneshot = 1'b1;
      step();
      bus.load = 1'b0; bus.en = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         total++; if (bus.out !== 4'(i)) begin bad++; $display("FAIL oneshot.count step %0d got %0d want %0d", i, bus.out, i); end
         total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL oneshot.early_done step %0d got %b want 0", i, bus.done); end
      end
      step();
      total++; if (bus.out !== 4'd5) begin bad++; $display("FAIL oneshot.halt_out got %0d want 5", bus.out); end
      total++; if (bus.wrap !== 1'b1) begin bad++; $display("FAIL oneshot.halt_wrap got %b want 1", bus.wrap); end
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL oneshot.halt_done got %b want 1", bus.done); end
      step();
      total++; if (bus.out !== 4'd5) begin bad++; $display("FAIL oneshot.hold_out got %0d want 5", bus.out); end
      total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL oneshot.hold_wrap got %b want 0", bus.wrap); end
      bus.oneshot = 1'b0;
      step();
      total++; if (bus.out !== 4'd5) begin bad++; $display("FAIL oneshot.clear_os_out got %0d want 5", bus.out); end
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL oneshot.clear_os_done got %b want 1", bus.done); end
      bus.load = 1'b1; bus.ld_val = 4'd2;
      step();
      total++; if (bus.out !== 4'd2) begin bad++; $display("FAIL oneshot.reload_out got %0d want 2", bus.out); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL oneshot.reload_done got %b want 0", bus.done); end
      bus.load = 1'b0;
      step();
      total++; if (bus.out !== 4'd3) begin bad++; $display("FAIL oneshot.resume got %0d want 3", bus.out); end
   endtask

   task automatic test_boundaries();
      // Load above the modulus in up mode: terminal on the next tick.
      bus.load = 1'b1; bus.ld_val = 4'd12; bus.en = 1'b0;
      bus.up = 1'b1; bus.modulus = 4'd9; bus.oneshot = 1'b0;
      step();
      total++; if (bus.tc !== 1'b1) begin bad++; $display("FAIL bound.over_tc got %b want 1", bus.tc); end
      bus.load = 1'b0; bus.en = 1'b1;
      step();
      total++; if (bus.out !== 4'd0) begin bad++; $display("FAIL bound.over_out got %0d want 0", bus.out); end
      total++; if (bus.wrap !== 1'b1) begin bad++; $display("FAIL bound.over_wrap got %b want 1", bus.wrap); end
      // Clear during the wrap pulse.
      #2 clr = 1'b1;
      #1;
      total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL bound.clr_wrap got %b want 0", bus.wrap); end
      @(negedge clk) clr = 1'b0;
      step();
      total++; if (bus.out !== 4'd1) begin bad++; $display("FAIL bound.after_clr got %0d want 1", bus.out); end
      // Direction change at the terminal value.
      bus.load = 1'b1; bus.ld_val = 4'd9;
      step();
      bus.load = 1'b0; bus.up = 1'b0;
      #1;
      total++; if (bus.tc !== 1'b0) begin bad++; $display("FAIL bound.dir_tc got %b want 0", bus.tc); end
      step();
      total++; if (bus.out !== 4'd8) begin bad++; $display("FAIL bound.dir_out got %0d want 8", bus.out); end
      total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL bound.dir_wrap got %b want 0", bus.wrap); end
      // modulus = 0 holds at 0 in both directions and wraps every tick.
      bus.load = 1'b1; bus.ld_val = 4'd0; bus.up = 1'b1; bus.modulus = 4'd0;
      step();
      bus.load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) bus.up = 1'b0;
         step();
         total++; if (bus.out !== 4'd0) begin bad++; $display("FAIL bound.mod0_out tick %0d got %0d want 0", i, bus.out); end
         total++; if (bus.wrap !== 1'b1) begin bad++; $display("FAIL bound.mod0_wrap tick %0d got %b want 1", i, bus.wrap); end
         total++; if (bus.tc !== 1'b1) begin bad++; $display("FAIL bound.mod0_tc tick %0d got %b want 1", i, bus.tc); end
      end
      // Load above the modulus in down mode decrements normally.
      bus.load = 1'b1; bus.ld_val = 4'd12; bus.modulus = 4'd9;
      step();
      bus.load = 1'b0;
      step();
      total++; if (bus.out !== 4'd11) begin bad++; $display("FAIL bound.over_down got %0d want 11", bus.out); end
      // Asynchronous clear mid-count.
      bus.load = 1'b1; bus.ld_val = 4'd6; bus.up = 1'b1;
      step();
      bus.load = 1'b0;
      #2 clr = 1'b1;
      #1;
      total++; if (bus.out !== 4'd0) begin bad++; $display("FAIL bound.clr_mid got %0d want 0", bus.out); end
      @(negedge clk) clr = 1'b0;
      step();
      total++; if (bus.out !== 4'd1) begin bad++; $display("FAIL bound.clr_resume got %0d want 1", bus.out); end
   endtask

`ifdef COUNTER_PRESCALE_EN
   task automatic test_prescale();
      logic [3:0] exp_out;
      bus_p.load = 1'b1; bus_p.ld_val = 4'd0; bus_p.en = 1'b1;
      bus_p.up = 1'b1; bus_p.modulus = 4'd9; bus_p.oneshot = 1'b0;
      step();
      bus_p.load = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         step();
         exp_out = 4'(k / 3);
         total++; if (bus_p.out !== exp_out) begin bad++; $display("FAIL prescale.out edge %0d got %0d want %0d", k, bus_p.out, exp_out); end
      end
      step();
      bus_p.en = 1'b0;
      step();
      step();
      total++; if (bus_p.out !== 4'd3) begin bad++; $display("FAIL prescale.paused got %0d want 3", bus_p.out); end
      bus_p.en = 1'b1;
      step();
      total++; if (bus_p.out !== 4'd3) begin bad++; $display("FAIL prescale.phase1 got %0d want 3", bus_p.out); end
      step();
      total++; if (bus_p.out !== 4'd4) begin bad++; $display("FAIL prescale.phase2 got %0d want 4", bus_p.out); end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      clr   = 1'b0;
      bus.en = 1'b0; bus.up = 1'b1; bus.oneshot = 1'b0; bus.load = 1'b0;
      bus.ld_val = 4'd0; bus.modulus = 4'd9;
`ifdef COUNTER_PRESCALE_EN
      bus_p.en = 1'b0; bus_p.up = 1'b1; bus_p.oneshot = 1'b0; bus_p.load = 1'b0;
      bus_p.ld_val = 4'd0; bus_p.modulus = 4'd9;
`endif
      @(negedge clk);
      test_reset();
      test_up_wrap();
      test_down_load();
      test_oneshot();
      test_boundaries();
`ifdef COUNTER_PRESCALE_EN
      test_prescale();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
